// File: rtl/replica_pkg.sv
`default_nettype none
// =============================================================================
// Module : replica_pkg
// Brief  : Shared types and constants for one replica slot of the salesman engine.
// Rev    : 1.0  initial release
// =============================================================================
package replica_pkg;

    localparam int city_num    = 4;                      // words per tour
    localparam int replica_num = 8;
    localparam int c_city_w    = 7;
    localparam int c_lanes     = 8;                      // cities per word
    localparam int c_lane_w    = 3;
    localparam int c_word_w    = $clog2(city_num);
    localparam int c_addr_w    = $clog2(2 * city_num);   // {bank, word}
    localparam int c_tour_len  = city_num * c_lanes;

    typedef logic [c_lanes-1:0][c_city_w-1:0] replica_data_t;
    typedef logic [5:0]                       city_idx_t;

    typedef enum logic [1:0] {
        NOP  = 2'd0,
        PREV = 2'd1,
        FOLW = 2'd2,
        SELF = 2'd3
    } replica_command_t;

    typedef enum logic [0:0] {
        THR = 1'b0,
        OR0 = 1'b1
    } opt_command_t;

    typedef struct packed {
        opt_command_t command;
        city_idx_t    K;
        city_idx_t    L;
    } opt_t;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } seq_state_t;

    // Degenerate or-opt moves collapse to a plain copy.
    function automatic logic or_opt_active(input opt_t o);
        return (o.command == OR0) && (o.K < o.L) && (o.L < city_idx_t'(c_tour_len));
    endfunction

endpackage
`default_nettype wire

// File: rtl/replica_ram_if.sv
`default_nettype none
// =============================================================================
// Module : replica_ram_if
// Brief  : Command, neighbour-chain and output bus of one replica slot.
// Rev    : 1.0  initial release
// =============================================================================
interface replica_ram_if;
    import replica_pkg::*;

    replica_command_t command;
    opt_t             opt;
    logic             rbank;
    logic             prev_valid;
    replica_data_t    prev_data;
    logic             folw_valid;
    replica_data_t    folw_data;
    logic             out_valid;
    replica_data_t    out_data;

    modport master (
        output command, opt, rbank, prev_valid, prev_data, folw_valid, folw_data,
        input  out_valid, out_data
    );

    modport slave (
        input  command, opt, rbank, prev_valid, prev_data, folw_valid, folw_data,
        output out_valid, out_data
    );

endinterface
`default_nettype wire

// File: rtl/replica_bank_ram.sv
`default_nettype none
// =============================================================================
// Module : replica_bank_ram
// Brief  : 1R1W synchronous RAM holding both tour banks, addressed {bank, word}.
// Rev    : 1.0  initial release
// =============================================================================
module replica_bank_ram
    import replica_pkg::*;
(
    input  wire                      clk,
    input  wire                      i_wr_en,
    input  wire [c_addr_w-1:0]       i_wr_addr,
    input  wire replica_data_t       i_wr_data,
    input  wire [c_addr_w-1:0]       i_rd_addr,
    output replica_data_t            o_rd_data
);

    replica_data_t r_mem [2*city_num];
    replica_data_t r_rd_data;

    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
        r_rd_data <= r_mem[i_rd_addr];
    end

    assign o_rd_data = r_rd_data;

endmodule
`default_nettype wire

// File: rtl/replica_ram.sv
`default_nettype none
// =============================================================================
// Module : replica_ram
// Brief  : Double-banked tour store of one replica; shifts tours along the chain
//          or rewrites them in place with an optional or-opt move.
// Rev    : 1.0  initial release
// =============================================================================
module replica_ram
    import replica_pkg::*;
(
    input  wire           clk,
    input  wire           reset,
    replica_ram_if.slave  bus
);

    localparam logic [2:0] c_seq_last = 3'(city_num + 3);
    localparam logic [2:0] c_words    = 3'(city_num);

    seq_state_t          r_state, w_state_nxt;
    logic [2:0]          r_cyc, w_cyc_nxt;
    replica_command_t    r_cmd;
    logic                r_bank;
    city_idx_t           r_k, r_l;
    logic                r_or_act;
    logic [2:0]          r_wr_cnt;
    logic                r_out_valid;
    replica_data_t       r_out_data;
    replica_data_t       r_hold;
    logic [c_word_w-1:0] r_hold_idx;
    logic                r_hold_vld;
    logic [c_city_w-1:0] r_kval;

    logic                w_run, w_start, w_q_vld, w_in_vld, w_fwd, w_wr_en;
    logic [c_word_w-1:0] w_q_idx, w_k_word;
    logic [c_lane_w-1:0] w_k_lane;
    logic [c_addr_w-1:0] w_rd_addr, w_wr_addr;
    replica_data_t       w_q, w_in_data, w_shift, w_new, w_wr_data;
    logic [c_city_w-1:0] w_k_eff;
    city_idx_t           w_pos;

    assign w_run   = (r_state == ST_RUN);
    assign w_start = !w_run && (bus.command != NOP);
    assign w_fwd   = (r_cmd == PREV) || (r_cmd == FOLW);

    // The command cycle itself reads word 0, so the bank comes straight from the bus then.
    assign w_rd_addr = {(w_run ? ~r_bank : ~bus.rbank), r_cyc[c_word_w-1:0]};
    assign w_q_vld   = w_run && (r_cyc != 3'd0) && (r_cyc <= c_words);
    assign w_q_idx   = r_cyc[c_word_w-1:0] - c_word_w'(1);

    assign w_in_vld  = w_run && (r_wr_cnt < c_words) &&
                       (((r_cmd == PREV) && bus.prev_valid) || ((r_cmd == FOLW) && bus.folw_valid));
    assign w_in_data = (r_cmd == FOLW) ? bus.folw_data : bus.prev_data;

    assign w_k_word  = r_k[c_lane_w +: c_word_w];
    assign w_k_lane  = r_k[c_lane_w-1:0];
    // old[K] may sit in the word being rewritten right now.
    assign w_k_eff   = (r_hold_idx == w_k_word) ? r_hold[w_k_lane] : r_kval;
    assign w_shift   = {w_q[0], r_hold[c_lanes-1:1]};

    always_comb begin
        w_new = r_hold;
        w_pos = '0;
        for (int l = 0; l < c_lanes; l++) begin
            w_pos = {1'b0, r_hold_idx, 3'(l)};
            if (r_or_act) begin
                if ((w_pos >= r_k) && (w_pos < r_l)) begin
                    w_new[l] = w_shift[l];
                end else if (w_pos == r_l) begin
                    w_new[l] = w_k_eff;
                end
            end
        end
    end

    assign w_wr_en   = r_hold_vld || w_in_vld;
    assign w_wr_addr = r_hold_vld ? {r_bank, r_hold_idx} : {r_bank, r_wr_cnt[c_word_w-1:0]};
    assign w_wr_data = r_hold_vld ? w_new : w_in_data;

    replica_bank_ram u_bank_ram (
        .clk       (clk),
        .i_wr_en   (w_wr_en),
        .i_wr_addr (w_wr_addr),
        .i_wr_data (w_wr_data),
        .i_rd_addr (w_rd_addr),
        .o_rd_data (w_q)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_cyc_nxt   = r_cyc;
        if (w_run) begin
            if (r_cyc == c_seq_last) begin
                w_state_nxt = ST_IDLE;
                w_cyc_nxt   = 3'd0;
            end else begin
                w_cyc_nxt   = r_cyc + 3'd1;
            end
        end else if (w_start) begin
            w_state_nxt = ST_RUN;
            w_cyc_nxt   = 3'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
            r_cyc   <= 3'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cyc   <= w_cyc_nxt;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cmd       <= NOP;
            r_bank      <= 1'b0;
            r_k         <= '0;
            r_l         <= '0;
            r_or_act    <= 1'b0;
            r_wr_cnt    <= 3'd0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_hold      <= '0;
            r_hold_idx  <= '0;
            r_hold_vld  <= 1'b0;
            r_kval      <= '0;
        end else begin
            if (w_start) begin
                r_cmd    <= bus.command;
                r_bank   <= bus.rbank;
                r_k      <= bus.opt.K;
                r_l      <= bus.opt.L;
                r_or_act <= or_opt_active(bus.opt);
                r_wr_cnt <= 3'd0;
            end else if (w_in_vld) begin
                r_wr_cnt <= r_wr_cnt + 3'd1;
            end

            r_out_valid <= w_q_vld && w_fwd;
            if (w_q_vld && w_fwd) begin
                r_out_data <= w_q;
            end

            // One-word look-ahead: hold word i while word i+1 is on the RAM output.
            r_hold_vld <= w_q_vld && (r_cmd == SELF);
            if (w_q_vld) begin
                r_hold     <= w_q;
                r_hold_idx <= w_q_idx;
            end
            if (r_hold_vld && (r_hold_idx == w_k_word)) begin
                r_kval <= r_hold[w_k_lane];
            end
        end
    end

    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_out_data;

endmodule
`default_nettype wire

// File: tb/tb_replica_ram.sv
`default_nettype none
// =============================================================================
// Module : tb_replica_ram
// Brief  : Self-checking bench for replica_ram: vector table plus output scoreboard.
// Rev    : 1.0  initial release
// =============================================================================
module tb_replica_ram;
    import replica_pkg::*;

    typedef logic [31:0][6:0] tour_t;

    typedef struct {
        int            cyc;
        replica_data_t data;
        bit            chk;
    } exp_t;

    typedef struct {
        replica_command_t cmd;
        opt_command_t     oc;
        int               k;
        int               l;
        int               src;
        int               nvalid;
        int               extra;
    } vec_t;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    replica_ram_if bus();

    replica_ram dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int            total = 0;
    int            bad   = 0;
    int            n_out = 0;
    exp_t          sb[$];
    tour_t         model [2];
    bit            known [2];
    logic          rb = 1'b0;
    replica_data_t last_out = '0;
    bit            last_known = 1'b1;
    tour_t         srcs [5];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h, want %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    exp_t mon_e;
    always @(negedge clk) begin
        if (reset && (bus.out_valid === 1'b1)) begin
            n_out++;
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected out_valid: got 1, want 0 (cycle %0d)", cyc);
            end else begin
                mon_e = sb.pop_front();
                check("out word cycle", 64'(cyc), 64'(mon_e.cyc));
                if (mon_e.chk) check("out word data", 64'(bus.out_data), 64'(mon_e.data));
            end
        end
    end

    function automatic tour_t or_model(input tour_t o, input opt_command_t oc, input int k, input int l);
        int    q[$];
        int    city;
        tour_t n;
        n = o;
        if ((oc == OR0) && (k < l) && (l < 32)) begin
            for (int p = 0; p < 32; p++) q.push_back(int'(o[p]));
            city = q[k];
            q.delete(k);
            q.insert(l, city);
            for (int p = 0; p < 32; p++) n[p] = 7'(q[p]);
        end
        return n;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        bus.command    = NOP;
        bus.opt        = '0;
        bus.prev_valid = 1'b0;
        bus.prev_data  = '0;
        bus.folw_valid = 1'b0;
        bus.folw_data  = '0;
    endtask

    task automatic push_reads(input int t);
        exp_t e;
        for (int w = 0; w < city_num; w++) begin
            e.cyc  = t + 2 + w;
            e.data = model[~rb][w*8 +: 8];
            e.chk  = known[~rb];
            sb.push_back(e);
        end
    endtask

    task automatic run_cmd(input replica_command_t cmd, input opt_command_t oc, input int k, input int l,
                           input tour_t src, input int nvalid, input int extra, input bit tog);
        int            t;
        int            outs0;
        tour_t         nxt;
        bit            nk;
        bit            fwd;
        replica_data_t d;
        fwd = (cmd == PREV) || (cmd == FOLW);
        if (tog) rb = ~rb;
        tick();
        t = cyc;
        bus.command     = cmd;
        bus.opt.command = oc;
        bus.opt.K       = city_idx_t'(k);
        bus.opt.L       = city_idx_t'(l);
        bus.rbank       = rb;
        if (fwd) push_reads(t);
        if (cmd == SELF) begin
            nxt = or_model(model[~rb], oc, k, l);
            nk  = known[~rb];
        end else begin
            nxt = src;
            nk  = 1'b1;
        end
        outs0 = n_out;
        for (int c = 1; c <= 9; c++) begin
            tick();
            bus.command    = (c == extra) ? SELF : NOP;
            bus.prev_valid = 1'b0;
            bus.folw_valid = 1'b0;
            if (fwd && (c >= 2) && (c < 2 + nvalid)) begin
                if (c - 2 < city_num) d = src[(c-2)*8 +: 8];
                else                  d = replica_data_t'({$urandom, $urandom});
                if (cmd == PREV) begin
                    bus.prev_valid = 1'b1;
                    bus.prev_data  = d;
                    bus.folw_valid = 1'b1;
                    bus.folw_data  = replica_data_t'({$urandom, $urandom});
                end else begin
                    bus.folw_valid = 1'b1;
                    bus.folw_data  = d;
                    bus.prev_valid = 1'b1;
                    bus.prev_data  = replica_data_t'({$urandom, $urandom});
                end
            end
        end
        check("out word count", 64'(n_out - outs0), fwd ? 64'd4 : 64'd0);
        check("scoreboard drained", 64'(sb.size()), 64'd0);
        if (fwd) begin
            last_out   = model[~rb][24 +: 8];
            last_known = known[~rb];
        end
        if (last_known) check("out_data hold", 64'(bus.out_data), 64'(last_out));
        model[rb] = nxt;
        known[rb] = nk;
    endtask

    task automatic abort_test();
        int t;
        rb = ~rb;
        tick();
        t = cyc;
        bus.command = PREV;
        bus.opt     = '0;
        bus.rbank   = rb;
        push_reads(t);
        tick();
        bus.command = NOP;
        tick();
        tick();
        #2;
        reset = 1'b0;
        #1;
        check("reset mid-seq out_valid", 64'(bus.out_valid), 64'd0);
        check("reset mid-seq out_data", 64'(bus.out_data), 64'd0);
        sb.delete();
        known[rb]  = 1'b0;
        last_out   = '0;
        last_known = 1'b1;
        tick();
        tick();
        reset = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vt [22];
        drive_idle();
        bus.rbank = 1'b0;
        known[0]  = 1'b0;
        known[1]  = 1'b0;
        for (int p = 0; p < 32; p++) begin
            srcs[0][p] = 7'(p);
            srcs[1][p] = 7'(31 - p);
            for (int r = 2; r < 5; r++) srcs[r][p] = 7'($urandom_range(0, 127));
        end

        vt = '{
            '{PREV, THR,  0,  0, 0, 4, 0},
            '{SELF, THR,  0,  0, 0, 0, 0},
            '{PREV, THR,  0,  0, 1, 4, 0},
            '{FOLW, THR,  0,  0, 0, 4, 3},
            '{SELF, OR0,  0, 10, 0, 0, 0},
            '{PREV, THR,  0,  0, 0, 5, 0},
            '{SELF, OR0,  9, 31, 0, 0, 0},
            '{PREV, THR,  0,  0, 0, 4, 0},
            '{SELF, OR0,  9,  9, 0, 0, 0},
            '{PREV, THR,  0,  0, 2, 4, 0},
            '{SELF, OR0,  3,  5, 0, 0, 0},
            '{FOLW, THR,  0,  0, 0, 4, 0},
            '{SELF, OR0,  2, 40, 0, 0, 0},
            '{PREV, THR,  0,  0, 3, 4, 0},
            '{SELF, OR0,  7,  8, 0, 0, 4},
            '{PREV, THR,  0,  0, 4, 4, 0},
            '{SELF, OR0, 20, 10, 0, 0, 0},
            '{PREV, THR,  0,  0, 0, 4, 0},
            '{SELF, OR0,  0, 31, 0, 0, 0},
            '{PREV, THR,  0,  0, 1, 4, 0},
            '{PREV, THR,  0,  0, 0, 4, 0},
            '{PREV, THR,  0,  0, 2, 4, 0}
        };

        repeat (3) tick();
        check("reset out_valid", 64'(bus.out_valid), 64'd0);
        check("reset out_data", 64'(bus.out_data), 64'd0);
        reset = 1'b1;
        tick();

        for (int i = 0; i < 22; i++) begin
            run_cmd(vt[i].cmd, vt[i].oc, vt[i].k, vt[i].l, srcs[vt[i].src],
                    vt[i].nvalid, vt[i].extra, 1'b1);
        end

        // Abort a PREV mid-stream, then restart it on the same banks.
        abort_test();
        run_cmd(PREV, THR, 0, 0, srcs[1], 4, 0, 1'b0);
        run_cmd(PREV, THR, 0, 0, srcs[0], 4, 0, 1'b1);
        run_cmd(PREV, THR, 0, 0, srcs[0], 4, 0, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
